// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB4 completer holding NUM_REGS word-wide registers. Register 0 is a
//   read-only ID word; registers 1..NUM_REGS-1 are read/write with byte
//   strobes. Good transfers take WAIT_CYCLES wait states; illegal accesses
//   complete with zero waits and PSLVERR=1.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL, PENABLE        APB select / access-phase indicator
//   PWRITE, PADDR        direction and byte address (latched at setup)
//   PWDATA, PSTRB        write data and byte strobes (sampled at completion)
//   PPROT                protection; bit 0 = privileged
//   PRDATA               registered read data, zero whenever PREADY=0
//   PREADY, PSLVERR      registered completion and error response
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001,
  parameter bit                    PRIV_ONLY   = 1'b0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int                    NUM_BYTES  = DATA_WIDTH / 8;
  localparam int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int                    IDX_SPAN   = 1 << IDX_W;
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic                    commit;

  // Only the privileged bit of PPROT matters here.
  logic unused_prot;
  assign unused_prot = ^PPROT[2:1];

  // Setup-phase decode. The offset is computed in full address width; an
  // address below the base wraps to a huge offset, but the explicit
  // below-base term flags it regardless.
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_err;

  assign word_idx  = (PADDR - BASE_ADDR) >> 2;
  assign setup_idx = word_idx[IDX_W-1:0];
  assign setup_err = (PADDR < BASE_ADDR)
                  || (word_idx >= NUM_REGS_A)
                  || (PADDR[1:0] != 2'b00)
                  || (PWRITE && (word_idx == '0))
                  || (PRIV_ONLY && !PPROT[0]);

  // Register file read port. The array spans the full index range so a
  // non-power-of-two NUM_REGS never indexes past its end; unused slots
  // read as zero and are only reachable on error transfers anyway.
  logic [DATA_WIDTH-1:0] reg_rd [IDX_SPAN];
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_value;

  assign rd_idx   = (state_q == ST_IDLE) ? setup_idx : index_q;
  assign rd_value = reg_rd[rd_idx];

  genvar gi;
  generate
    for (gi = 0; gi < IDX_SPAN; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign reg_rd[gi] = ID_VALUE;
      end else if (gi < NUM_REGS) begin : g_rw
        logic [DATA_WIDTH-1:0] word_q, word_d;

        always_comb begin
          word_d = word_q;
          if (commit && (index_q == IDX_W'(gi))) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
              if (PSTRB[b]) begin
                word_d[8*b +: 8] = PWDATA[8*b +: 8];
              end
            end
          end
        end

        always_ff @(posedge PCLK or negedge PRESETn) begin
          if (!PRESETn) begin
            word_q <= '0;
          end else begin
            word_q <= word_d;
          end
        end

        assign reg_rd[gi] = word_q;
      end else begin : g_pad
        assign reg_rd[gi] = '0;
      end
    end
  endgenerate

  // Transfer sequencer: IDLE -> (WAIT) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    index_d   = index_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    commit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          write_d = PWRITE;
          index_d = setup_idx;
          err_d   = setup_err;
          cnt_d   = WAIT_INIT;
          if (setup_err || (WAIT_CYCLES == 0)) begin
            // Errors and zero-wait configs answer in the first access cycle.
            state_d   = ST_DONE;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (PWRITE || setup_err) ? '0 : rd_value;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!PSEL) begin
          // Master abandoned the transfer: nothing is committed.
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (cnt_q == 4'd1) begin
            state_d   = ST_DONE;
            cnt_d     = 4'd0;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (write_q || err_q) ? '0 : rd_value;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      ST_DONE: begin
        // Completion edge. A dropped PSEL here also releases the bus so the
        // slave cannot stick with PREADY high, but only a real completion
        // commits the write.
        if (!PSEL || PENABLE) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          commit    = PSEL && write_q && !err_q;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      index_q   <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      index_q   <= index_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
//   Two slave instances on one bus with separate selects:
//     dut_a : WAIT_CYCLES=1, PRIV_ONLY=0
//     dut_b : WAIT_CYCLES=0, PRIV_ONLY=1
//   A table of directed transfers with hand-computed results, followed by
//   hand-written sequences for reset, abandoned and stalled transfers.
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk;
  logic        presetn;
  logic        psel_a, psel_b;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] a_prdata, b_prdata;
  logic        a_pready, b_pready;
  logic        a_pslverr, b_pslverr;

  int total = 0;
  int bad   = 0;

  apb_regfile_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(1), .ID_VALUE(ID), .PRIV_ONLY(1'b0)
  ) dut_a (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_a), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  apb_regfile_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(0), .ID_VALUE(ID), .PRIV_ONLY(1'b1)
  ) dut_b (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_b), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    bit          dut_b;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit b, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [2:0] prot, input logic [31:0] exp_rdata,
                     input bit exp_err, input int exp_cyc);
    vec_t v;
    v.dut_b = b; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.prot = prot; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_cyc = exp_cyc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full transfer. Called at #1 after an edge; leaves the bus idle at #1
  // after the completion edge so a following call is back-to-back.
  task automatic xfer(input bit b, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, output logic [31:0] rdata,
                      output logic err, output int cyc, output logic rdy,
                      output logic rdy_after);
    psel_a  = !b;
    psel_b  = b;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    rdy = b ? b_pready : a_pready;
    while (!rdy && cyc < 20) begin
      @(posedge pclk); #1;
      cyc++;
      rdy = b ? b_pready : a_pready;
    end
    rdata = b ? b_prdata : a_prdata;
    err   = b ? b_pslverr : a_pslverr;
    @(posedge pclk); #1;
    rdy_after = b ? b_pready : a_pready;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic run_chk(input string tag, input bit b, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot,
                         input logic [31:0] exp_rdata, input bit exp_err,
                         input int exp_cyc);
    logic [31:0] rdata;
    logic        err, rdy, rdy_after;
    int          cyc;
    xfer(b, wr, addr, wdata, strb, prot, rdata, err, cyc, rdy, rdy_after);
    $display("%s dut=%s %s addr=%h wdata=%h strb=%b prot=%b -> rdata=%h err=%0d cyc=%0d",
             tag, b ? "b" : "a", wr ? "WR" : "RD", addr, wdata, strb, prot,
             rdata, err, cyc);
    chk({tag, " ready_seen"}, 32'(rdy), 32'd1);
    chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " prdata"}, rdata, exp_rdata);
    chk({tag, " pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, " pready_drop"}, 32'(rdy_after), 32'd0);
  endtask

  initial begin
    presetn = 1'b1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;

    // dut_a: one wait state, no privilege filter
    add(0, 1, 32'h08, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0,          0, 2);
    add(0, 0, 32'h08, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF,  0, 2);
    add(0, 1, 32'h04, 32'h1122_3344, 4'h5, 3'b000, 32'h0,          0, 2);
    add(0, 0, 32'h04, 32'h0,         4'hF, 3'b000, 32'h0022_0044,  0, 2);
    add(0, 0, 32'h40, 32'h0,         4'h0, 3'b000, 32'h0,          1, 1);
    add(0, 1, 32'h00, 32'h1234_5678, 4'hF, 3'b000, 32'h0,          1, 1);
    add(0, 0, 32'h06, 32'h0,         4'h0, 3'b000, 32'h0,          1, 1);
    add(0, 0, 32'h00, 32'h0,         4'h0, 3'b000, ID,             0, 2);
    add(0, 0, 32'h08, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF,  0, 2);
    add(0, 0, 32'h04, 32'h0,         4'h0, 3'b000, 32'h0022_0044,  0, 2);
    add(0, 1, 32'h3C, 32'hAAAA_5555, 4'h0, 3'b000, 32'h0,          0, 2);
    add(0, 0, 32'h3C, 32'h0,         4'h0, 3'b000, 32'h0,          0, 2);
    add(0, 1, 32'h3C, 32'hCAFE_F00D, 4'hA, 3'b000, 32'h0,          0, 2);
    add(0, 0, 32'h3C, 32'h0,         4'h0, 3'b000, 32'hCA00_F000,  0, 2);
    add(0, 1, 32'h04, 32'h0000_AA00, 4'h2, 3'b000, 32'h0,          0, 2);
    add(0, 0, 32'h04, 32'h0,         4'h0, 3'b000, 32'h0022_AA44,  0, 2);
    add(0, 1, 32'h0C, 32'h0000_0077, 4'hF, 3'b000, 32'h0,          0, 2);
    add(0, 0, 32'h0C, 32'h0,         4'h0, 3'b000, 32'h0000_0077,  0, 2);
    // dut_b: zero waits, privileged-only
    add(1, 1, 32'h04, 32'h5566_7788, 4'hF, 3'b000, 32'h0,          1, 1);
    add(1, 0, 32'h04, 32'h0,         4'h0, 3'b001, 32'h0,          0, 1);
    add(1, 1, 32'h04, 32'h5566_7788, 4'hF, 3'b001, 32'h0,          0, 1);
    add(1, 0, 32'h04, 32'h0,         4'h0, 3'b001, 32'h5566_7788,  0, 1);
    add(1, 1, 32'h0C, 32'h0BAD_F00D, 4'hF, 3'b001, 32'h0,          0, 1);
    add(1, 0, 32'h0C, 32'h0,         4'h0, 3'b001, 32'h0BAD_F00D,  0, 1);
    add(1, 0, 32'h00, 32'h0,         4'h0, 3'b001, ID,             0, 1);
    add(1, 0, 32'h04, 32'h0,         4'h0, 3'b000, 32'h0,          1, 1);
    add(1, 0, 32'h44, 32'h0,         4'h0, 3'b001, 32'h0,          1, 1);

    // Power-on reset
    #2 presetn = 1'b0;
    #1;
    chk("rst a_pready",  32'(a_pready),  32'd0);
    chk("rst a_prdata",  a_prdata,       32'd0);
    chk("rst a_pslverr", 32'(a_pslverr), 32'd0);
    chk("rst b_pready",  32'(b_pready),  32'd0);
    chk("rst b_prdata",  b_prdata,       32'd0);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;

    // Table: every entry follows the previous one with no idle cycle.
    foreach (vecs[i]) begin
      run_chk($sformatf("vec%0d", i), vecs[i].dut_b, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].strb, vecs[i].prot, vecs[i].exp_rdata,
              vecs[i].exp_err, vecs[i].exp_cyc);
    end

    // Reset during WAIT of a write to reg 3 (which currently holds 0x77).
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    $display("seq reset_in_wait pready=%0d prdata=%h", a_pready, a_prdata);
    chk("rstwait pready", 32'(a_pready), 32'd0);
    chk("rstwait prdata", a_prdata,      32'd0);
    psel_a = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;
    run_chk("rstwait_rd3", 0, 0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h0, 0, 2);
    run_chk("rstwait_rd2", 0, 0, 32'h08, 32'h0, 4'h0, 3'b000, 32'h0, 0, 2);

    // Asynchronous reset while PREADY is high on an ID read.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h00;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("rstdone pre_pready", 32'(a_pready), 32'd1);
    chk("rstdone pre_prdata", a_prdata,      ID);
    #2 presetn = 1'b0;
    #1;
    $display("seq reset_in_done pready=%0d prdata=%h", a_pready, a_prdata);
    chk("rstdone pready", 32'(a_pready), 32'd0);
    chk("rstdone prdata", a_prdata,      32'd0);
    psel_a = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;

    // PSEL dropped during WAIT: no completion, no write.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h0000_0099; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    psel_a = 1'b0; penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      chk($sformatf("abandon pready%0d", k), 32'(a_pready), 32'd0);
    end
    $display("seq abandon write reg4 pready=%0d", a_pready);
    run_chk("abandon_rd4", 0, 0, 32'h10, 32'h0, 4'h0, 3'b000, 32'h0, 0, 2);

    // PENABLE held low in WAIT: the transfer stalls, then completes normally.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h00;
    @(posedge pclk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      chk($sformatf("stall pready%0d", k), 32'(a_pready), 32'd0);
    end
    penable = 1'b1;
    #1;
    chk("stall acc1 pready", 32'(a_pready), 32'd0);
    @(posedge pclk); #1;
    chk("stall acc2 pready", 32'(a_pready), 32'd1);
    chk("stall acc2 prdata", a_prdata,      ID);
    chk("stall acc2 pslverr", 32'(a_pslverr), 32'd0);
    @(posedge pclk); #1;
    $display("seq stall read id pready_after=%0d prdata_after=%h", a_pready, a_prdata);
    chk("stall drop pready", 32'(a_pready), 32'd0);
    chk("stall drop prdata", a_prdata,      32'd0);
    psel_a = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
